// File: rtl/cnn_pkg.sv
// Shared CNN image geometry, address-width helper and input-loader state encoding.
package cnn_pkg;

    localparam int PIX_W = 8;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int PAD   = 2;
    localparam int CNT_W = 16;

    localparam int PW = IMG_W + 32'sd2 * PAD;
    localparam int PH = IMG_H + 32'sd2 * PAD;
    localparam int N  = PW * PH;

    // Smallest address width (at least one bit) that reaches n locations.
    function automatic int calc_addr_w(input int n);
        int w;
        int span;
        w    = 32'sd1;
        span = 32'sd2;
        while (span < n) begin
            w    = w + 32'sd1;
            span = span * 32'sd2;
        end
        return w;
    endfunction

    localparam int ADDR_W = calc_addr_w(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/pad_scan_counter.sv
// Raster-order walker over a zero-padded frame: row/col, a linear address and
// border/last flags. The address is stepped by one, never computed as row*PW+col.
module pad_scan_counter #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int PAD    = cnn_pkg::PAD,
    parameter int ADDR_W = cnn_pkg::calc_addr_w((IMG_W + 32'sd2 * PAD) * (IMG_H + 32'sd2 * PAD))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_row,
    output logic [ADDR_W-1:0] o_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_is_border,
    output logic              o_is_last
);

    localparam int PW = IMG_W + 32'sd2 * PAD;
    localparam int PH = IMG_H + 32'sd2 * PAD;
    localparam int N  = PW * PH;

    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(PW - 32'sd1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(N - 32'sd1);
    localparam logic [ADDR_W-1:0] ROW_END  = ADDR_W'(PAD + IMG_H);
    localparam logic [ADDR_W-1:0] COL_END  = ADDR_W'(PAD + IMG_W);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(32'd1);

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_addr;
    logic              w_top;
    logic              w_left;

    // Without padding the top/left tests collapse to constants.
    generate
        if (PAD == 0) begin : g_nopad
            assign w_top  = 1'b0;
            assign w_left = 1'b0;
        end else begin : g_pad
            localparam logic [ADDR_W-1:0] PAD_V = ADDR_W'(PAD);
            assign w_top  = (r_row < PAD_V);
            assign w_left = (r_col < PAD_V);
        end
    endgenerate

    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_addr      = r_addr;
    assign o_is_border = w_top || w_left || (r_row >= ROW_END) || (r_col >= COL_END);
    assign o_is_last   = (r_addr == ADDR_MAX);

    // Scan position: cleared on request, stepped per advance, wraps after the last slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row  <= {ADDR_W{1'b0}};
            r_col  <= {ADDR_W{1'b0}};
            r_addr <= {ADDR_W{1'b0}};
        end else if (i_clear || (i_advance && o_is_last)) begin
            r_row  <= {ADDR_W{1'b0}};
            r_col  <= {ADDR_W{1'b0}};
            r_addr <= {ADDR_W{1'b0}};
        end else if (i_advance) begin
            r_addr <= r_addr + STEP;
            if (r_col == COL_MAX) begin
                r_col <= {ADDR_W{1'b0}};
                r_row <= r_row + STEP;
            end else begin
                r_col <= r_col + STEP;
            end
        end
    end

endmodule

// File: rtl/img_input_loader.sv
// Loads one image from a valid/ready pixel stream into the padded layer-1 buffer,
// writing zero borders itself, and pulses done_img_input once the frame is complete.
module img_input_loader #(
    parameter int PIX_W  = cnn_pkg::PIX_W,
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int PAD    = cnn_pkg::PAD,
    parameter int ADDR_W = cnn_pkg::ADDR_W,
    parameter int CNT_W  = cnn_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              srt_input,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              done_img_input,
    output logic [CNT_W-1:0]  img_count
);

    import cnn_pkg::*;

    loader_state_e     r_state;
    loader_state_e     w_next_state;
    logic              r_srt_d;
    logic              w_srt_rise;
    logic              w_clear;
    logic              w_issue;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_is_border;
    logic              w_is_last;
    logic              w_unused_rc;

    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [PIX_W-1:0]  r_mem_wdata;
    logic              r_done;
    logic [CNT_W-1:0]  r_img_count;

    pad_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PAD    (PAD),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_advance   (w_issue),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_addr      (w_addr),
        .o_is_border (w_is_border),
        .o_is_last   (w_is_last)
    );

    // Row/col are exported for other scan users; this stage only needs the address.
    assign w_unused_rc = ^{w_row, w_col};
    assign w_srt_rise  = srt_input & ~r_srt_d;

    // Next state, scan control and the stream handshake.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_issue      = 1'b0;
        s_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_srt_rise) begin
                    w_clear      = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                s_ready = ~w_is_border;
                w_issue = w_is_border | s_valid;
                if (!srt_input) begin
                    w_next_state = ST_IDLE;
                end else if (w_issue && w_is_last) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_FLUSH: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register and the srt_input level used for rise detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_srt_d <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_srt_d <= srt_input;
        end
    end

    // Write port lags the issuing cycle by one; done and the count fire on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {PIX_W{1'b0}};
            r_done      <= 1'b0;
            r_img_count <= {CNT_W{1'b0}};
        end else begin
            r_mem_we <= w_issue;
            if (w_issue) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_is_border ? {PIX_W{1'b0}} : s_data;
            end
            r_done <= (r_state == ST_FLUSH);
            if (r_state == ST_FLUSH) begin
                r_img_count <= r_img_count + CNT_W'(32'd1);
            end
        end
    end

    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign done_img_input = r_done;
    assign img_count      = r_img_count;
    assign busy           = (r_state == ST_LOAD) || (r_state == ST_FLUSH);

endmodule
